multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_ctrl_pkg.sv | 71 +++++++
 rtl/multicycle_control_alu_op_decode.sv | 53 +++++
 rtl/multicycle_control.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared definitions for the multicycle MIPS control unit:
//               FSM state encoding, ALU operation codes, mux select codes,
//               and the ISA opcode/funct constants the decoder dispatches on.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // FSM states; FETCH must stay at 0 so the debug port reads 0000 in reset
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_R     = 4'd7,
        WB_I     = 4'd8,
        WB_MEM   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    // ALU operation codes
    localparam logic [2:0] c_alu_add   = 3'b000;
    localparam logic [2:0] c_alu_sub   = 3'b001;
    localparam logic [2:0] c_alu_shift = 3'b010;  // shifts, set-less-than, lui
    localparam logic [2:0] c_alu_and   = 3'b011;
    localparam logic [2:0] c_alu_or    = 3'b100;
    localparam logic [2:0] c_alu_xor   = 3'b101;
    localparam logic [2:0] c_alu_nor   = 3'b110;
    localparam logic [2:0] c_alu_none  = 3'b111;

    // ALU B-operand select
    localparam logic [1:0] c_srcb_reg     = 2'b00;
    localparam logic [1:0] c_srcb_four    = 2'b01;
    localparam logic [1:0] c_srcb_imm     = 2'b10;
    localparam logic [1:0] c_srcb_imm_sl2 = 2'b11;

    // PC source select
    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jtgt   = 2'b10;
    localparam logic [1:0] c_pcsrc_rs     = 2'b11;

    // ISA opcodes and funct codes referenced by the control unit
    localparam logic [5:0] c_op_rtype    = 6'b000000;
    localparam logic [5:0] c_op_j        = 6'b000010;
    localparam logic [5:0] c_op_jal      = 6'b000011;
    localparam logic [5:0] c_op_beq      = 6'b000100;
    localparam logic [5:0] c_op_bne      = 6'b000101;
    localparam logic [5:0] c_op_lw       = 6'b100011;
    localparam logic [5:0] c_op_sw       = 6'b101011;
    localparam logic [5:0] c_funct_jr    = 6'b001000;
    localparam logic [5:0] c_funct_jalr  = 6'b001001;

    // Opcode class prefixes (upper bits) used for dispatch
    localparam logic [2:0] c_cls_itype   = 3'b001;
    localparam logic [2:0] c_cls_load    = 3'b100;
    localparam logic [2:0] c_cls_store   = 3'b101;

    // True for R-type register jumps (jr/jalr share funct prefix 00100)
    function automatic logic is_reg_jump(input logic [5:0] funct);
        return (funct[5:1] == c_funct_jr[5:1]);
    endfunction

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/multicycle_control_alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Combinational mapping from funct (R-type) and opcode
//               (I-type) to ALU operation code and immediate sign-extend.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [2:0] o_r_alu_op,
    output logic       o_r_sign_xtend,
    output logic [2:0] o_i_alu_op,
    output logic       o_i_sign_xtend
);

    // R-type: ALU operation selected by funct
    always_comb begin
        o_r_alu_op = c_alu_none;
        casez (i_funct)
            6'b10000?: o_r_alu_op = c_alu_add;
            6'b10001?: o_r_alu_op = c_alu_sub;
            6'b000???: o_r_alu_op = c_alu_shift;
            6'b1010??: o_r_alu_op = c_alu_shift;
            6'b100100: o_r_alu_op = c_alu_and;
            6'b100101: o_r_alu_op = c_alu_or;
            6'b100110: o_r_alu_op = c_alu_xor;
            6'b100111: o_r_alu_op = c_alu_nor;
            default:   o_r_alu_op = c_alu_none;
        endcase
        // odd funct codes are the unsigned variants
        o_r_sign_xtend = ~i_funct[0];
    end

    // I-type: ALU operation selected by opcode; logical immediates zero-extend
    always_comb begin
        o_i_alu_op = c_alu_none;
        casez (i_opcode)
            6'b00100?: o_i_alu_op = c_alu_add;
            6'b00101?: o_i_alu_op = c_alu_shift;
            6'b001100: o_i_alu_op = c_alu_and;
            6'b001101: o_i_alu_op = c_alu_or;
            6'b001110: o_i_alu_op = c_alu_xor;
            6'b001111: o_i_alu_op = c_alu_shift;
            default:   o_i_alu_op = c_alu_none;
        endcase
        o_i_sign_xtend = (i_opcode[5:2] == 4'b0010) ? ~i_opcode[0] : 1'b0;
    end

endmodule : alu_op_decode
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle MIPS control FSM. Sequences fetch, decode,
//               execute, memory and write-back, and drives the datapath
//               mux selects, ALU operation and write strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem2reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic       sign_xtend,
    output logic       instr_done,
    output logic       illegal,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next;

    logic       w_pc_write, w_ir_write, w_iord, w_mem_read, w_mem_write;
    logic       w_mem2reg, w_reg_dst, w_reg_write, w_alu_src_a, w_sign_xtend;
    logic       w_instr_done, w_illegal;
    logic [1:0] w_alu_src_b, w_pc_src;
    logic [2:0] w_alu_op;

    logic [2:0] w_r_alu_op, w_i_alu_op;
    logic       w_r_sign_xtend, w_i_sign_xtend;

    alu_op_decode u_alu_op_decode (
        .i_opcode       (opcode),
        .i_funct        (funct),
        .o_r_alu_op     (w_r_alu_op),
        .o_r_sign_xtend (w_r_sign_xtend),
        .o_i_alu_op     (w_i_alu_op),
        .o_i_sign_xtend (w_i_sign_xtend)
    );

    // State register; reset returns to FETCH and abandons any instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state datapath controls
    always_comb begin
        w_next       = r_state;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem2reg    = 1'b0;
        w_reg_dst    = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_sign_xtend = 1'b0;
        w_instr_done = 1'b0;
        w_illegal    = 1'b0;
        w_alu_src_b  = c_srcb_reg;
        w_pc_src     = c_pcsrc_alu;
        w_alu_op     = c_alu_none;

        case (r_state)
            FETCH: begin
                // PC+4 computed every fetch cycle, committed only on completion
                w_mem_read  = 1'b1;
                w_alu_src_b = c_srcb_four;
                w_alu_op    = c_alu_add;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = DECODE;
                end
            end
            DECODE: begin
                // Speculative branch target into ALUOut
                w_alu_src_b = c_srcb_imm_sl2;
                w_alu_op    = c_alu_add;
                casez (opcode)
                    c_op_rtype: w_next = is_reg_jump(funct) ? JUMP : EXEC_R;
                    6'b00001?:  w_next = JUMP;
                    6'b00010?:  w_next = BRANCH;
                    6'b001???:  w_next = EXEC_I;
                    6'b10????:  w_next = MEM_ADDR;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = FETCH;
                    end
                endcase
            end
            EXEC_R: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = c_srcb_reg;
                w_alu_op     = w_r_alu_op;
                w_sign_xtend = w_r_sign_xtend;
                w_next       = WB_R;
            end
            EXEC_I: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = c_srcb_imm;
                w_alu_op     = w_i_alu_op;
                w_sign_xtend = w_i_sign_xtend;
                w_next       = WB_I;
            end
            MEM_ADDR: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = c_srcb_imm;
                w_alu_op     = c_alu_add;
                w_sign_xtend = 1'b1;
                w_next       = (opcode[5:3] == c_cls_store) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                w_iord     = 1'b1;
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_next = WB_MEM;
                end
            end
            MEM_WR: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) begin
                    w_instr_done = 1'b1;
                    w_next       = FETCH;
                end
            end
            WB_R: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 1'b1;
                w_instr_done = 1'b1;
                w_next       = FETCH;
            end
            WB_I: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = FETCH;
            end
            WB_MEM: begin
                w_reg_write  = 1'b1;
                w_mem2reg    = 1'b1;
                w_instr_done = 1'b1;
                w_next       = FETCH;
            end
            BRANCH: begin
                // opcode[0] distinguishes bne from beq
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = c_srcb_reg;
                w_alu_op     = c_alu_sub;
                w_pc_src     = c_pcsrc_aluout;
                w_pc_write   = zero ^ opcode[0];
                w_instr_done = 1'b1;
                w_next       = FETCH;
            end
            JUMP: begin
                w_pc_write   = 1'b1;
                w_pc_src     = (opcode == c_op_rtype) ? c_pcsrc_rs : c_pcsrc_jtgt;
                w_instr_done = 1'b1;
                w_next       = FETCH;
            end
            default: begin
                w_next = FETCH;
            end
        endcase
    end

    // Reset forces every output (including the debug state) to zero
    assign pc_write   = reset ? 1'b0 : w_pc_write;
    assign ir_write   = reset ? 1'b0 : w_ir_write;
    assign iord       = reset ? 1'b0 : w_iord;
    assign mem_read   = reset ? 1'b0 : w_mem_read;
    assign mem_write  = reset ? 1'b0 : w_mem_write;
    assign mem2reg    = reset ? 1'b0 : w_mem2reg;
    assign reg_dst    = reset ? 1'b0 : w_reg_dst;
    assign reg_write  = reset ? 1'b0 : w_reg_write;
    assign alu_src_a  = reset ? 1'b0 : w_alu_src_a;
    assign sign_xtend = reset ? 1'b0 : w_sign_xtend;
    assign instr_done = reset ? 1'b0 : w_instr_done;
    assign illegal    = reset ? 1'b0 : w_illegal;
    assign alu_src_b  = reset ? 2'b00 : w_alu_src_b;
    assign pc_src     = reset ? 2'b00 : w_pc_src;
    assign alu_op     = reset ? 3'b000 : w_alu_op;
    assign state      = reset ? 4'b0000 : r_state;

endmodule : multicycle_control
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Scoreboard bench for multicycle_control. The driver applies
//               one directed vector per cycle and queues the hand-computed
//               expected outputs; the monitor pops and compares each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    // Strobe bit masks, order {pc_write .. illegal}
    localparam logic [11:0] c_pcw  = 12'h800;
    localparam logic [11:0] c_irw  = 12'h400;
    localparam logic [11:0] c_iord = 12'h200;
    localparam logic [11:0] c_mrd  = 12'h100;
    localparam logic [11:0] c_mwr  = 12'h080;
    localparam logic [11:0] c_m2r  = 12'h040;
    localparam logic [11:0] c_rdst = 12'h020;
    localparam logic [11:0] c_rwr  = 12'h010;
    localparam logic [11:0] c_asa  = 12'h008;
    localparam logic [11:0] c_sx   = 12'h004;
    localparam logic [11:0] c_done = 12'h002;
    localparam logic [11:0] c_ill  = 12'h001;

    // Debug state codes
    localparam logic [3:0] c_s_f   = 4'd0;
    localparam logic [3:0] c_s_d   = 4'd1;
    localparam logic [3:0] c_s_exr = 4'd2;
    localparam logic [3:0] c_s_exi = 4'd3;
    localparam logic [3:0] c_s_ma  = 4'd4;
    localparam logic [3:0] c_s_mr  = 4'd5;
    localparam logic [3:0] c_s_mw  = 4'd6;
    localparam logic [3:0] c_s_wbr = 4'd7;
    localparam logic [3:0] c_s_wbi = 4'd8;
    localparam logic [3:0] c_s_wbm = 4'd9;
    localparam logic [3:0] c_s_br  = 4'd10;
    localparam logic [3:0] c_s_j   = 4'd11;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, iord, mem_read, mem_write, mem2reg;
    logic       reg_dst, reg_write, alu_src_a, sign_xtend, instr_done, illegal;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic [3:0] state;

    typedef struct {
        string      name;
        logic [3:0] st;
        logic [11:0] sb;
        logic [1:0] srcb;
        logic [1:0] pcs;
        logic [2:0] aop;
        bit         care_aop;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem2reg    (mem2reg),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .sign_xtend (sign_xtend),
        .instr_done (instr_done),
        .illegal    (illegal),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus its expected response
    task automatic step(input string name, input logic [5:0] op, input logic [5:0] fn,
                        input logic rst, input logic mr, input logic z,
                        input logic [3:0] st, input logic [11:0] sb,
                        input logic [1:0] srcb, input logic [1:0] pcs,
                        input logic [2:0] aop, input bit care);
        exp_t e;
        @(posedge clk);
        #1;
        opcode    = op;
        funct     = fn;
        reset     = rst;
        mem_ready = mr;
        zero      = z;
        e.name = name; e.st = st; e.sb = sb; e.srcb = srcb;
        e.pcs = pcs; e.aop = aop; e.care_aop = care;
        q.push_back(e);
    endtask

    // Fetch (mem_ready=1) then decode of a legal instruction
    task automatic fetch_decode(input string name, input logic [5:0] op, input logic [5:0] fn,
                                input logic z);
        step({name, "_fetch"}, op, fn, 1'b0, 1'b1, z, c_s_f, c_pcw | c_irw | c_mrd,
             2'b01, 2'b00, 3'b000, 1'b1);
        step({name, "_decode"}, op, fn, 1'b0, 1'b1, z, c_s_d, 12'h000,
             2'b11, 2'b00, 3'b000, 1'b1);
    endtask

    // R-type ALU instruction after decode
    task automatic r_tail(input string name, input logic [5:0] fn, input logic [2:0] aop,
                          input logic [11:0] exsb);
        step({name, "_exec"}, 6'b000000, fn, 1'b0, 1'b1, 1'b0, c_s_exr, exsb,
             2'b00, 2'b00, aop, 1'b1);
        step({name, "_wb"}, 6'b000000, fn, 1'b0, 1'b1, 1'b0, c_s_wbr, c_rwr | c_rdst | c_done,
             2'b00, 2'b00, 3'b000, 1'b0);
    endtask

    // I-type ALU instruction after decode
    task automatic i_tail(input string name, input logic [5:0] op, input logic [2:0] aop,
                          input logic [11:0] exsb);
        step({name, "_exec"}, op, 6'h00, 1'b0, 1'b1, 1'b0, c_s_exi, exsb,
             2'b10, 2'b00, aop, 1'b1);
        step({name, "_wb"}, op, 6'h00, 1'b0, 1'b1, 1'b0, c_s_wbi, c_rwr | c_done,
             2'b00, 2'b00, 3'b000, 1'b0);
    endtask

    // Driver: directed instruction sequence
    initial begin
        reset = 1'b1; opcode = 6'h3f; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;

        step("reset0", 6'h3f, 6'h00, 1'b1, 1'b1, 1'b1, c_s_f, 12'h000, 2'b00, 2'b00, 3'b000, 1'b1);
        step("reset1", 6'h3f, 6'h00, 1'b1, 1'b1, 1'b1, c_s_f, 12'h000, 2'b00, 2'b00, 3'b000, 1'b1);

        fetch_decode("add", 6'b000000, 6'b100000, 1'b0);
        r_tail("add", 6'b100000, 3'b000, c_asa | c_sx);
        fetch_decode("sub", 6'b000000, 6'b100010, 1'b0);
        r_tail("sub", 6'b100010, 3'b001, c_asa | c_sx);
        fetch_decode("or", 6'b000000, 6'b100101, 1'b0);
        r_tail("or", 6'b100101, 3'b100, c_asa);
        fetch_decode("sll", 6'b000000, 6'b000000, 1'b0);
        r_tail("sll", 6'b000000, 3'b010, c_asa | c_sx);
        fetch_decode("nor", 6'b000000, 6'b100111, 1'b0);
        r_tail("nor", 6'b100111, 3'b110, c_asa);

        fetch_decode("addi", 6'b001000, 6'h00, 1'b0);
        i_tail("addi", 6'b001000, 3'b000, c_asa | c_sx);
        fetch_decode("ori", 6'b001101, 6'h00, 1'b0);
        i_tail("ori", 6'b001101, 3'b100, c_asa);
        fetch_decode("lui", 6'b001111, 6'h00, 1'b0);
        i_tail("lui", 6'b001111, 3'b010, c_asa);

        // lw with two wait cycles in MEM_RD: 7 cycles total
        fetch_decode("lw", 6'b100011, 6'h00, 1'b0);
        step("lw_addr", 6'b100011, 6'h00, 1'b0, 1'b1, 1'b0, c_s_ma, c_asa | c_sx, 2'b10, 2'b00, 3'b000, 1'b1);
        step("lw_rd0",  6'b100011, 6'h00, 1'b0, 1'b0, 1'b0, c_s_mr, c_iord | c_mrd, 2'b00, 2'b00, 3'b000, 1'b0);
        step("lw_rd1",  6'b100011, 6'h00, 1'b0, 1'b0, 1'b0, c_s_mr, c_iord | c_mrd, 2'b00, 2'b00, 3'b000, 1'b0);
        step("lw_rd2",  6'b100011, 6'h00, 1'b0, 1'b1, 1'b0, c_s_mr, c_iord | c_mrd, 2'b00, 2'b00, 3'b000, 1'b0);
        step("lw_wb",   6'b100011, 6'h00, 1'b0, 1'b1, 1'b0, c_s_wbm, c_rwr | c_m2r | c_done, 2'b00, 2'b00, 3'b000, 1'b0);

        // beq taken, bne not taken, both with zero=1
        fetch_decode("beq", 6'b000100, 6'h00, 1'b1);
        step("beq_br", 6'b000100, 6'h00, 1'b0, 1'b1, 1'b1, c_s_br, c_pcw | c_asa | c_done, 2'b00, 2'b01, 3'b001, 1'b1);
        fetch_decode("bne", 6'b000101, 6'h00, 1'b1);
        step("bne_br", 6'b000101, 6'h00, 1'b0, 1'b1, 1'b1, c_s_br, c_asa | c_done, 2'b00, 2'b01, 3'b001, 1'b1);

        // Jumps: J-type target and register jump
        fetch_decode("j", 6'b000010, 6'h00, 1'b0);
        step("j_jump", 6'b000010, 6'h00, 1'b0, 1'b1, 1'b0, c_s_j, c_pcw | c_done, 2'b00, 2'b10, 3'b000, 1'b0);
        fetch_decode("jr", 6'b000000, 6'b001000, 1'b0);
        step("jr_jump", 6'b000000, 6'b001000, 1'b0, 1'b1, 1'b0, c_s_j, c_pcw | c_done, 2'b00, 2'b11, 3'b000, 1'b0);

        // Illegal opcode: pulse in DECODE, straight back to FETCH
        step("ill_fetch", 6'b111111, 6'h00, 1'b0, 1'b1, 1'b0, c_s_f, c_pcw | c_irw | c_mrd, 2'b01, 2'b00, 3'b000, 1'b1);
        step("ill_decode", 6'b111111, 6'h00, 1'b0, 1'b1, 1'b0, c_s_d, c_ill, 2'b11, 2'b00, 3'b000, 1'b1);
        // FETCH stalls while memory is not ready
        step("fetch_stall", 6'b101011, 6'h00, 1'b0, 1'b0, 1'b0, c_s_f, c_mrd, 2'b01, 2'b00, 3'b000, 1'b1);

        // sw with one wait cycle
        fetch_decode("sw", 6'b101011, 6'h00, 1'b0);
        step("sw_addr", 6'b101011, 6'h00, 1'b0, 1'b1, 1'b0, c_s_ma, c_asa | c_sx, 2'b10, 2'b00, 3'b000, 1'b1);
        step("sw_wr0",  6'b101011, 6'h00, 1'b0, 1'b0, 1'b0, c_s_mw, c_iord | c_mwr, 2'b00, 2'b00, 3'b000, 1'b0);
        step("sw_wr1",  6'b101011, 6'h00, 1'b0, 1'b1, 1'b0, c_s_mw, c_iord | c_mwr | c_done, 2'b00, 2'b00, 3'b000, 1'b0);

        // sw abandoned by reset in MEM_WR
        fetch_decode("swr", 6'b101011, 6'h00, 1'b0);
        step("swr_addr", 6'b101011, 6'h00, 1'b0, 1'b1, 1'b0, c_s_ma, c_asa | c_sx, 2'b10, 2'b00, 3'b000, 1'b1);
        step("swr_rst0", 6'b101011, 6'h00, 1'b1, 1'b1, 1'b0, c_s_f, 12'h000, 2'b00, 2'b00, 3'b000, 1'b1);
        step("swr_rst1", 6'b101011, 6'h00, 1'b1, 1'b1, 1'b0, c_s_f, 12'h000, 2'b00, 2'b00, 3'b000, 1'b1);
        fetch_decode("post", 6'b000000, 6'b100100, 1'b0);
        r_tail("post", 6'b100100, 3'b011, c_asa | c_sx);

        @(posedge clk);
        done = 1'b1;
    end

    // Monitor: compare every cycle that has a queued expectation
    initial begin : monitor
        exp_t        e;
        logic [11:0] act;
        bit          bad;
        int          cycles;
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {pc_write, ir_write, iord, mem_read, mem_write, mem2reg,
                       reg_dst, reg_write, alu_src_a, sign_xtend, instr_done, illegal};
                bad = (state !== e.st) || (act !== e.sb) || (alu_src_b !== e.srcb) ||
                      (pc_src !== e.pcs) || (e.care_aop && (alu_op !== e.aop));
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL %s: got state=%h strobes=%h src_b=%b pc_src=%b alu_op=%b, expected state=%h strobes=%h src_b=%b pc_src=%b alu_op=%b%s",
                             e.name, state, act, alu_src_b, pc_src, alu_op,
                             e.st, e.sb, e.srcb, e.pcs, e.aop, e.care_aop ? "" : " (alu_op ignored)");
                end
            end
            if (done && q.size() == 0) break;
            if (cycles > 5000) begin
                errors++;
                $display("FAIL watchdog: got %0d cycles with %0d pending, expected completion", cycles, q.size());
                break;
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_multicycle_control
`default_nettype wire
